// File: rtl/pc_gen_btb.sv
// Fetch program-counter unit: PC register with trap/redirect/stall priority and a
// direct-mapped branch target buffer with 2-bit saturating counters for next-fetch prediction.
module pc_gen_btb #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o
);

    localparam int unsigned     IDX        = $clog2(BTB_ENTRIES);
    localparam int unsigned     TAG_W      = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0]  pc_q;
    logic             pc_valid_q;
    logic [XLEN-1:0]  pc_next;

    logic             btb_valid  [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_target [BTB_ENTRIES];

    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             unused_upd_lsbs;

    assign look_idx = pc_q[IDX+1:2];
    assign look_tag = pc_q[XLEN-1:IDX+2];
    assign look_hit = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);

    assign upd_idx  = upd_pc_i[IDX+1:2];
    assign upd_tag  = upd_pc_i[XLEN-1:IDX+2];
    assign upd_hit  = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

    // Instruction alignment makes the two low bits of the trained PC meaningless.
    assign unused_upd_lsbs = ^upd_pc_i[1:0];

    assign pc_o          = pc_q;
    assign pc_valid_o    = pc_valid_q;
    assign pred_taken_o  = pc_valid_q && look_hit && btb_ctr[look_idx][1];
    assign pred_target_o = btb_target[look_idx];

    always_comb begin
        pc_next = pc_q + XLEN'(4);
        if (!pc_valid_q)      pc_next = pc_q;
        else if (trap_i)      pc_next = trap_vec_i & ALIGN_MASK;
        else if (redirect_i)  pc_next = redirect_pc_i & ALIGN_MASK;
        else if (stall_i)     pc_next = pc_q;
        else if (pred_taken_o) pc_next = pred_target_o;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_next;
            pc_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b01;
            end
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                if (upd_taken_i && btb_ctr[upd_idx] != 2'b11)
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
                else if (!upd_taken_i && btb_ctr[upd_idx] != 2'b00)
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
            end else if (upd_taken_i) begin
                btb_valid[upd_idx] <= 1'b1;
                btb_ctr[upd_idx]   <= 2'b10;
            end
        end
    end

    // NOTE: tag/target storage has no reset; a cleared valid bit makes stale contents unobservable.
    always_ff @(posedge clk) begin
        if (upd_valid_i && upd_taken_i) begin
            btb_target[upd_idx] <= upd_target_i;
            if (!upd_hit)
                btb_tag[upd_idx] <= upd_tag;
        end
    end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Self-checking bench for pc_gen_btb: directed scenarios plus randomized traffic
// compared against an arithmetic model of the PC priority rules and the BTB.
module tb_pc_gen_btb;

    localparam int unsigned N  = 16;
    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0, redirect_i = 1'b0, trap_i = 1'b0;
    logic [31:0] redirect_pc_i = '0, trap_vec_i = '0;
    logic        upd_valid_i = 1'b0, upd_taken_i = 1'b0;
    logic [31:0] upd_pc_i = '0, upd_target_i = '0;
    logic [31:0] pc_o, pred_target_o;
    logic        pc_valid_o, pred_taken_o;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [31:0] m_pc;
    bit          m_pcv;
    bit          m_valid [N];
    logic [31:0] m_owner [N];
    int          m_ctr   [N];
    logic [31:0] m_tgt   [N];

    pc_gen_btb #(.XLEN(32), .RESET_VECTOR(RV), .BTB_ENTRIES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
        .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o),
        .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o)
    );

    always #5 clk = ~clk;

    function automatic int slot(logic [31:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic logic [31:0] block(logic [31:0] a);
        return a / (4 * N);
    endfunction

    function automatic bit m_pred();
        int s = slot(m_pc);
        return m_pcv && m_valid[s] && (m_owner[s] == block(m_pc)) && (m_ctr[s] >= 2);
    endfunction

    task automatic model_reset();
        m_pc  = RV;
        m_pcv = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
            m_owner[i] = '0;
            m_tgt[i]   = '0;
        end
    endtask

    task automatic clear_inputs();
        stall_i = 0; redirect_i = 0; trap_i = 0; upd_valid_i = 0; upd_taken_i = 0;
    endtask

    // Advance one clock; the model takes its next state from the inputs in force before the edge.
    task automatic clk_step();
        logic [31:0] npc;
        int s;
        if (!m_pcv)          npc = m_pc;
        else if (trap_i)     npc = {trap_vec_i[31:2], 2'b00};
        else if (redirect_i) npc = {redirect_pc_i[31:2], 2'b00};
        else if (stall_i)    npc = m_pc;
        else if (m_pred())   npc = m_tgt[slot(m_pc)];
        else                 npc = m_pc + 32'd4;
        if (upd_valid_i) begin
            s = slot(upd_pc_i);
            if (m_valid[s] && m_owner[s] == block(upd_pc_i)) begin
                if (upd_taken_i) begin
                    m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                    m_tgt[s] = upd_target_i;
                end else begin
                    m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                end
            end else if (upd_taken_i) begin
                m_valid[s] = 1'b1;
                m_owner[s] = block(upd_pc_i);
                m_tgt[s]   = upd_target_i;
                m_ctr[s]   = 2;
            end
        end
        @(posedge clk);
        #1;
        m_pc  = npc;
        m_pcv = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] seq [3] = '{32'h100, 32'h104, 32'h108};
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (pc_o !== RV) begin bad++; $display("FAIL reset_pc: got %h want %h", pc_o, RV); end
        total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pc_valid_o); end
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL reset_pred: got %b want 0", pred_taken_o); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            total++; if (pc_o !== seq[i]) begin bad++; $display("FAIL release_pc%0d: got %h want %h", i, pc_o, seq[i]); end
            total++; if (pc_valid_o !== 1'b1) begin bad++; $display("FAIL release_valid%0d: got %b want 1", i, pc_valid_o); end
        end
    endtask

    task automatic test_stall();
        stall_i = 1;
        repeat (2) begin
            clk_step();
            total++; if (pc_o !== 32'h108) begin bad++; $display("FAIL stall_hold: got %h want 00000108", pc_o); end
        end
        redirect_i = 1; redirect_pc_i = 32'h200;
        clk_step();
        total++; if (pc_o !== 32'h200) begin bad++; $display("FAIL redirect_over_stall: got %h want 00000200", pc_o); end
        clear_inputs();
    endtask

    task automatic test_trap_priority();
        trap_i = 1; trap_vec_i = 32'h80; redirect_i = 1; redirect_pc_i = 32'h300;
        clk_step();
        total++; if (pc_o !== 32'h80) begin bad++; $display("FAIL trap_over_redirect: got %h want 00000080", pc_o); end
        trap_i = 0; redirect_pc_i = 32'h302;
        clk_step();
        total++; if (pc_o !== 32'h300) begin bad++; $display("FAIL redirect_align: got %h want 00000300", pc_o); end
        trap_i = 1; redirect_i = 0; trap_vec_i = 32'h87;
        clk_step();
        total++; if (pc_o !== 32'h84) begin bad++; $display("FAIL trap_align: got %h want 00000084", pc_o); end
        clear_inputs();
    endtask

    task automatic test_btb_train();
        redirect_i = 1; redirect_pc_i = 32'h10;
        upd_valid_i = 1; upd_pc_i = 32'h10; upd_taken_i = 1; upd_target_i = 32'h40;
        clk_step();
        total++; if (pred_taken_o !== 1'b1) begin bad++; $display("FAIL train_pred: got %b want 1", pred_taken_o); end
        total++; if (pred_target_o !== 32'h40) begin bad++; $display("FAIL train_target: got %h want 00000040", pred_target_o); end
        clear_inputs();
        clk_step();
        total++; if (pc_o !== 32'h40) begin bad++; $display("FAIL follow_pred: got %h want 00000040", pc_o); end
        // Two not-taken updates, fetching 0x10 each time.
        redirect_i = 1; redirect_pc_i = 32'h10; upd_valid_i = 1; upd_pc_i = 32'h10; upd_taken_i = 0;
        repeat (2) clk_step();
        clear_inputs();
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL weak_pred: got %b want 0", pred_taken_o); end
        clk_step();
        total++; if (pc_o !== 32'h14) begin bad++; $display("FAIL fallthrough: got %h want 00000014", pc_o); end
        // Third not-taken must saturate at 00: one taken afterwards still predicts not-taken.
        upd_valid_i = 1; upd_pc_i = 32'h10; upd_taken_i = 0;
        clk_step();
        upd_taken_i = 1; redirect_i = 1; redirect_pc_i = 32'h10;
        clk_step();
        clear_inputs();
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL sat_low: got %b want 0", pred_taken_o); end
    endtask

    task automatic test_alias();
        redirect_i = 1; redirect_pc_i = 32'h10;
        upd_valid_i = 1; upd_pc_i = 32'h10 + 4 * N; upd_taken_i = 1; upd_target_i = 32'h90;
        clk_step();
        clear_inputs();
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL alias_evict: got %b want 0", pred_taken_o); end
        redirect_i = 1; redirect_pc_i = 32'h10 + 4 * N;
        clk_step();
        clear_inputs();
        total++; if (pred_taken_o !== 1'b1) begin bad++; $display("FAIL alias_hit: got %b want 1", pred_taken_o); end
        total++; if (pred_target_o !== 32'h90) begin bad++; $display("FAIL alias_target: got %h want 00000090", pred_target_o); end
    endtask

    task automatic test_same_cycle();
        // pc_o sits on the aliased entry (ctr=10); a not-taken update this cycle must not bypass.
        upd_valid_i = 1; upd_pc_i = 32'h10 + 4 * N; upd_taken_i = 0;
        clk_step();
        clear_inputs();
        total++; if (pc_o !== 32'h90) begin bad++; $display("FAIL no_bypass: got %h want 00000090", pc_o); end
        redirect_i = 1; redirect_pc_i = 32'h10 + 4 * N;
        clk_step();
        clear_inputs();
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL update_visible: got %b want 0", pred_taken_o); end
    endtask

    task automatic test_wrap();
        redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
        clk_step();
        clear_inputs();
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL wrap_pred: got %b want 0", pred_taken_o); end
        clk_step();
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 00000000", pc_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall_i      = ($urandom_range(0, 4) == 0);
            redirect_i   = ($urandom_range(0, 9) == 0);
            trap_i       = ($urandom_range(0, 29) == 0);
            redirect_pc_i = $urandom_range(0, 255);
            trap_vec_i    = $urandom_range(0, 255);
            upd_valid_i  = ($urandom_range(0, 2) != 0);
            upd_taken_i  = ($urandom_range(0, 2) != 0);
            upd_pc_i     = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 1) * 4 * N);
            upd_target_i = 32'($urandom_range(0, 63) * 4);
            clk_step();
            total++; if (pc_o !== m_pc) begin bad++; $display("FAIL rand_pc@%0d: got %h want %h", n, pc_o, m_pc); end
            total++; if (pred_taken_o !== m_pred()) begin bad++; $display("FAIL rand_pred@%0d: got %b want %b", n, pred_taken_o, m_pred()); end
            if (m_pred()) begin
                total++;
                if (pred_target_o !== m_tgt[slot(m_pc)]) begin
                    bad++; $display("FAIL rand_target@%0d: got %h want %h", n, pred_target_o, m_tgt[slot(m_pc)]);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        // Train 0x50, then assert reset while another update is pending.
        redirect_i = 1; redirect_pc_i = 32'h50;
        upd_valid_i = 1; upd_pc_i = 32'h50; upd_taken_i = 1; upd_target_i = 32'hA0;
        clk_step();
        upd_pc_i = 32'h54;
        #2 rst_n = 1'b0;
        #1;
        total++; if (pc_o !== RV) begin bad++; $display("FAIL midreset_pc: got %h want %h", pc_o, RV); end
        total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", pc_valid_o); end
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL midreset_pred: got %b want 0", pred_taken_o); end
        @(posedge clk);
        #1;
        clear_inputs();
        model_reset();
        rst_n = 1'b1;
        clk_step();
        total++; if (pc_o !== RV || pc_valid_o !== 1'b1) begin
            bad++; $display("FAIL midreset_release: got %h/%b want %h/1", pc_o, pc_valid_o, RV);
        end
        redirect_i = 1; redirect_pc_i = 32'h50;
        clk_step();
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL midreset_btb_clear: got %b want 0", pred_taken_o); end
        redirect_pc_i = 32'h54;
        clk_step();
        clear_inputs();
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL midreset_discard: got %b want 0", pred_taken_o); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_trap_priority();
        test_btb_train();
        test_alias();
        test_same_cycle();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
